// File: rtl/windowed_register_file_if.sv
`default_nettype none
// ============================================================================
// Module   : windowed_register_file_if
// Purpose  : Read/write/window-control bundle for windowed_register_file.
// Revision : 1.0
// ============================================================================
interface windowed_register_file_if #(
   parameter int WIDTH    = 32,
   parameter int NWINDOWS = 4
);
   localparam int CWPW = $clog2(NWINDOWS);

   logic [4:0]          rs1;
   logic [4:0]          rs2;
   logic [WIDTH-1:0]    rdata1;
   logic [WIDTH-1:0]    rdata2;
   logic [4:0]          rd;
   logic [WIDTH-1:0]    wdata;
   logic                we;
   logic                save;
   logic                restore;
   logic                wim_we;
   logic [NWINDOWS-1:0] wim_in;
   logic [CWPW-1:0]     cwp;
   logic [NWINDOWS-1:0] wim;
   logic                window_overflow;
   logic                window_underflow;

   modport master (
      output rs1, rs2, rd, wdata, we, save, restore, wim_we, wim_in,
      input  rdata1, rdata2, cwp, wim, window_overflow, window_underflow
   );

   modport slave (
      input  rs1, rs2, rd, wdata, we, save, restore, wim_we, wim_in,
      output rdata1, rdata2, cwp, wim, window_overflow, window_underflow
   );
endinterface
`default_nettype wire

// File: rtl/windowed_register_file.sv
`default_nettype none
// ============================================================================
// Module   : windowed_register_file
// Purpose  : SPARC V8 windowed integer register file with CWP/WIM and traps.
// Revision : 1.0
// ============================================================================
module windowed_register_file #(
   parameter int WIDTH    = 32,
   parameter int NWINDOWS = 4,
   parameter int BYPASS   = 1
) (
   input  logic                     Clk,
   input  logic                     Clr,
   windowed_register_file_if.slave  bus
);
   localparam int CWPW  = $clog2(NWINDOWS);
   localparam int WREGS = NWINDOWS * 16;
   localparam int NPHYS = 8 + WREGS;
   localparam int PW    = $clog2(NPHYS);
   localparam int SW    = CWPW + 5;
   localparam logic [SW-1:0]   WREGS_S = SW'(WREGS);
   localparam logic [CWPW-1:0] CWP_MAX = CWPW'(NWINDOWS - 1);

   logic [WIDTH-1:0]    regs_q [0:NPHYS-1];
   logic [CWPW-1:0]     cwp_q, cwp_d;
   logic [NWINDOWS-1:0] wim_q, wim_d;
   logic                ovf_q, ovf_d;
   logic                unf_q, unf_d;

   logic [CWPW-1:0]     cwp_dec, cwp_inc;
   logic [PW-1:0]       rs1_phys, rs2_phys, rd_phys;
   logic                wr_en;
   logic [WIDTH-1:0]    rdata1, rdata2;

   // Globals occupy physical 0..7; windowed registers follow, wrapping so the
   // top window's ins land on window 0's outs.
   function automatic logic [PW-1:0] phys_idx(input logic [4:0] r,
                                              input logic [CWPW-1:0] c);
      logic [SW-1:0] s;
      s = SW'({c, 4'b0000}) + SW'(r) - SW'(8);
      if (s >= WREGS_S) s = s - WREGS_S;
      if (r < 5'd8) return PW'(r);
      return PW'(s) + PW'(8);
   endfunction

   assign rs1_phys = phys_idx(bus.rs1, cwp_q);
   assign rs2_phys = phys_idx(bus.rs2, cwp_q);
   assign rd_phys  = phys_idx(bus.rd,  cwp_q);
   assign wr_en    = bus.we && !Clr && (bus.rd != 5'd0);

   always_comb begin
      rdata1 = regs_q[rs1_phys];
      rdata2 = regs_q[rs2_phys];
      if (bus.rs1 == 5'd0)
         rdata1 = '0;
      else if ((BYPASS != 0) && wr_en && (rs1_phys == rd_phys))
         rdata1 = bus.wdata;
      if (bus.rs2 == 5'd0)
         rdata2 = '0;
      else if ((BYPASS != 0) && wr_en && (rs2_phys == rd_phys))
         rdata2 = bus.wdata;
   end

   always_comb begin
      cwp_dec = (cwp_q == '0)     ? CWP_MAX : cwp_q - CWPW'(1);
      cwp_inc = (cwp_q == CWP_MAX) ? '0     : cwp_q + CWPW'(1);
      cwp_d   = cwp_q;
      wim_d   = bus.wim_we ? bus.wim_in : wim_q;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      // The invalid-window check always sees the pre-edge WIM.
      if (bus.save && !bus.restore) begin
         if (wim_q[cwp_dec]) ovf_d = 1'b1;
         else                cwp_d = cwp_dec;
      end else if (bus.restore && !bus.save) begin
         if (wim_q[cwp_inc]) unf_d = 1'b1;
         else                cwp_d = cwp_inc;
      end
   end

   always_ff @(posedge Clk) begin
      if (Clr) begin
         for (int i = 0; i < NPHYS; i++) regs_q[i] <= '0;
         cwp_q <= '0;
         wim_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         if (wr_en) regs_q[rd_phys] <= bus.wdata;
         cwp_q <= cwp_d;
         wim_q <= wim_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign bus.rdata1           = rdata1;
   assign bus.rdata2           = rdata2;
   assign bus.cwp              = cwp_q;
   assign bus.wim              = wim_q;
   assign bus.window_overflow  = ovf_q;
   assign bus.window_underflow = unf_q;
endmodule
`default_nettype wire

// File: tb/tb_windowed_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_windowed_register_file
// Purpose  : Directed self-checking bench for windowed_register_file.
// Revision : 1.0
// ============================================================================
module tb_windowed_register_file;
   logic Clk = 1'b0;
   logic Clr = 1'b1;
   int   vectors = 0;
   int   errors  = 0;

   windowed_register_file_if #(.WIDTH(32), .NWINDOWS(4)) bus ();
   windowed_register_file_if #(.WIDTH(32), .NWINDOWS(4)) bus_nb ();

   windowed_register_file #(.WIDTH(32), .NWINDOWS(4), .BYPASS(1)) u_dut (
      .Clk (Clk),
      .Clr (Clr),
      .bus (bus)
   );

   windowed_register_file #(.WIDTH(32), .NWINDOWS(4), .BYPASS(0)) u_dut_nb (
      .Clk (Clk),
      .Clr (Clr),
      .bus (bus_nb)
   );

   always #5 Clk = ~Clk;

   task automatic idle();
      bus.rs1 = 5'd0;    bus.rs2 = 5'd0;    bus.rd = 5'd0;   bus.wdata = 32'd0;
      bus.we = 1'b0;     bus.save = 1'b0;   bus.restore = 1'b0;
      bus.wim_we = 1'b0; bus.wim_in = 4'd0;
      bus_nb.rs1 = 5'd0;    bus_nb.rs2 = 5'd0;    bus_nb.rd = 5'd0;   bus_nb.wdata = 32'd0;
      bus_nb.we = 1'b0;     bus_nb.save = 1'b0;   bus_nb.restore = 1'b0;
      bus_nb.wim_we = 1'b0; bus_nb.wim_in = 4'd0;
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      idle();
      Clr = 1'b1;
      tick();
      tick();
      Clr = 1'b0;
      vectors++;
      if (bus.cwp !== 2'd0) begin
         $display("FAIL reset_cwp: got %0d expected 0", bus.cwp); errors++;
      end
      vectors++;
      if (bus.wim !== 4'd0) begin
         $display("FAIL reset_wim: got %b expected 0000", bus.wim); errors++;
      end
      vectors++;
      if (bus.window_overflow !== 1'b0 || bus.window_underflow !== 1'b0) begin
         $display("FAIL reset_traps: got ovf=%b unf=%b expected 0 0",
                  bus.window_overflow, bus.window_underflow); errors++;
      end
      for (int w = 0; w < 4; w++) begin
         vectors++;
         if (bus.cwp !== 2'(w)) begin
            $display("FAIL reset_walk_cwp: got %0d expected %0d", bus.cwp, w); errors++;
         end
         for (int r = 0; r < 32; r++) begin
            bus.rs1 = 5'(r);
            bus.rs2 = 5'(31 - r);
            #1;
            vectors++;
            if (bus.rdata1 !== 32'd0 || bus.rdata2 !== 32'd0) begin
               $display("FAIL reset_read w=%0d r=%0d: got %h/%h expected 0/0",
                        w, r, bus.rdata1, bus.rdata2); errors++;
            end
         end
         bus.restore = 1'b1;
         tick();
         bus.restore = 1'b0;
      end
      vectors++;
      if (bus.cwp !== 2'd0) begin
         $display("FAIL reset_walk_wrap: got %0d expected 0", bus.cwp); errors++;
      end
   endtask

   task automatic test_windowing();
      bus.we = 1'b1; bus.rd = 5'd1;  bus.wdata = 32'h11;
      tick();
      bus.rd = 5'd16; bus.wdata = 32'h1600;
      tick();
      bus.we = 1'b0;
      bus.save = 1'b1;
      tick();
      bus.save = 1'b0;
      vectors++;
      if (bus.cwp !== 2'd3) begin
         $display("FAIL win_save_cwp: got %0d expected 3", bus.cwp); errors++;
      end
      bus.rs1 = 5'd1; bus.rs2 = 5'd16;
      #1;
      vectors++;
      if (bus.rdata1 !== 32'h11) begin
         $display("FAIL win_global_r1: got %h expected 00000011", bus.rdata1); errors++;
      end
      vectors++;
      if (bus.rdata2 !== 32'h0) begin
         $display("FAIL win_r16_w3: got %h expected 00000000", bus.rdata2); errors++;
      end
      bus.restore = 1'b1;
      tick();
      bus.restore = 1'b0;
      #1;
      vectors++;
      if (bus.cwp !== 2'd0 || bus.rdata2 !== 32'h1600) begin
         $display("FAIL win_restore_r16: got cwp=%0d %h expected cwp=0 00001600",
                  bus.cwp, bus.rdata2); errors++;
      end
   endtask

   task automatic test_overlap();
      bus.we = 1'b1; bus.rd = 5'd8; bus.wdata = 32'hA5;
      tick();
      bus.we = 1'b0;
      bus.save = 1'b1;
      tick();
      bus.save = 1'b0;
      bus.rs1 = 5'd24;
      #1;
      vectors++;
      if (bus.cwp !== 2'd3 || bus.rdata1 !== 32'hA5) begin
         $display("FAIL overlap_r24_w3: got cwp=%0d %h expected cwp=3 000000a5",
                  bus.cwp, bus.rdata1); errors++;
      end
      bus.restore = 1'b1;
      tick();
      bus.restore = 1'b0;
      bus.rs1 = 5'd8;
      #1;
      vectors++;
      if (bus.cwp !== 2'd0 || bus.rdata1 !== 32'hA5) begin
         $display("FAIL overlap_r8_w0: got cwp=%0d %h expected cwp=0 000000a5",
                  bus.cwp, bus.rdata1); errors++;
      end
   endtask

   task automatic test_traps();
      bus.wim_we = 1'b1; bus.wim_in = 4'b1000;
      tick();
      bus.wim_we = 1'b0;
      vectors++;
      if (bus.wim !== 4'b1000) begin
         $display("FAIL trap_wim_load: got %b expected 1000", bus.wim); errors++;
      end
      bus.save = 1'b1;
      tick();
      bus.save = 1'b0;
      vectors++;
      if (bus.cwp !== 2'd0 || bus.window_overflow !== 1'b1 || bus.window_underflow !== 1'b0) begin
         $display("FAIL trap_ovf: got cwp=%0d ovf=%b unf=%b expected 0 1 0",
                  bus.cwp, bus.window_overflow, bus.window_underflow); errors++;
      end
      tick();
      vectors++;
      if (bus.window_overflow !== 1'b0) begin
         $display("FAIL trap_ovf_one_cycle: got %b expected 0", bus.window_overflow); errors++;
      end
      bus.wim_we = 1'b1; bus.wim_in = 4'b0010;
      tick();
      bus.wim_we = 1'b0;
      bus.restore = 1'b1;
      tick();
      vectors++;
      if (bus.cwp !== 2'd0 || bus.window_underflow !== 1'b1 || bus.window_overflow !== 1'b0) begin
         $display("FAIL trap_unf: got cwp=%0d unf=%b ovf=%b expected 0 1 0",
                  bus.cwp, bus.window_underflow, bus.window_overflow); errors++;
      end
      tick();
      bus.restore = 1'b0;
      vectors++;
      if (bus.window_underflow !== 1'b1) begin
         $display("FAIL trap_unf_back_to_back: got %b expected 1", bus.window_underflow); errors++;
      end
      tick();
      vectors++;
      if (bus.window_underflow !== 1'b0) begin
         $display("FAIL trap_unf_drop: got %b expected 0", bus.window_underflow); errors++;
      end
      // WIM rewrite in the same cycle as a faulting RESTORE: old mask decides.
      bus.wim_we = 1'b1; bus.wim_in = 4'b0000; bus.restore = 1'b1;
      tick();
      bus.wim_we = 1'b0; bus.restore = 1'b0;
      vectors++;
      if (bus.window_underflow !== 1'b1 || bus.wim !== 4'b0000 || bus.cwp !== 2'd0) begin
         $display("FAIL trap_wim_same_cycle: got unf=%b wim=%b cwp=%0d expected 1 0000 0",
                  bus.window_underflow, bus.wim, bus.cwp); errors++;
      end
      bus.restore = 1'b1;
      tick();
      bus.restore = 1'b0;
      vectors++;
      if (bus.cwp !== 2'd1 || bus.window_underflow !== 1'b0) begin
         $display("FAIL trap_restore_after_clear: got cwp=%0d unf=%b expected 1 0",
                  bus.cwp, bus.window_underflow); errors++;
      end
      bus.save = 1'b1;
      tick();
      bus.save = 1'b0;
      vectors++;
      if (bus.cwp !== 2'd0) begin
         $display("FAIL trap_save_back: got cwp=%0d expected 0", bus.cwp); errors++;
      end
   endtask

   task automatic test_bypass();
      bus.we = 1'b1;    bus.rd = 5'd5;    bus.wdata = 32'h1234;    bus.rs1 = 5'd5;    bus.rs2 = 5'd0;
      bus_nb.we = 1'b1; bus_nb.rd = 5'd5; bus_nb.wdata = 32'h1234; bus_nb.rs1 = 5'd5;
      #1;
      vectors++;
      if (bus.rdata1 !== 32'h1234) begin
         $display("FAIL bypass_fwd: got %h expected 00001234", bus.rdata1); errors++;
      end
      vectors++;
      if (bus_nb.rdata1 !== 32'h0) begin
         $display("FAIL nobypass_old: got %h expected 00000000", bus_nb.rdata1); errors++;
      end
      tick();
      bus.we = 1'b0; bus_nb.we = 1'b0;
      #1;
      vectors++;
      if (bus_nb.rdata1 !== 32'h1234 || bus.rdata1 !== 32'h1234) begin
         $display("FAIL bypass_stored: got nb=%h b=%h expected 00001234 00001234",
                  bus_nb.rdata1, bus.rdata1); errors++;
      end
      bus.we = 1'b1; bus.rd = 5'd0; bus.wdata = 32'hDEAD; bus.rs2 = 5'd0;
      #1;
      vectors++;
      if (bus.rdata2 !== 32'h0) begin
         $display("FAIL bypass_r0: got %h expected 00000000", bus.rdata2); errors++;
      end
      tick();
      bus.we = 1'b0;
      #1;
      vectors++;
      if (bus.rdata2 !== 32'h0) begin
         $display("FAIL r0_after_write: got %h expected 00000000", bus.rdata2); errors++;
      end
      bus.we = 1'b1; bus.rd = 5'd20; bus.wdata = 32'h2020; bus.rs1 = 5'd20;
      #1;
      vectors++;
      if (bus.rdata1 !== 32'h2020) begin
         $display("FAIL bypass_windowed: got %h expected 00002020", bus.rdata1); errors++;
      end
      tick();
      bus.we = 1'b0;
   endtask

   task automatic test_simultaneous();
      bus.wim_we = 1'b1; bus.wim_in = 4'b1000;
      tick();
      bus.wim_we = 1'b0;
      bus.save = 1'b1; bus.restore = 1'b1;
      tick();
      bus.save = 1'b0; bus.restore = 1'b0;
      vectors++;
      if (bus.cwp !== 2'd0 || bus.window_overflow !== 1'b0 || bus.window_underflow !== 1'b0) begin
         $display("FAIL both_req: got cwp=%0d ovf=%b unf=%b expected 0 0 0",
                  bus.cwp, bus.window_overflow, bus.window_underflow); errors++;
      end
      bus.wim_we = 1'b1; bus.wim_in = 4'b0000;
      tick();
      bus.wim_we = 1'b0;
      bus.we = 1'b1; bus.rd = 5'd16; bus.wdata = 32'hBEEF; bus.save = 1'b1;
      tick();
      bus.we = 1'b0; bus.save = 1'b0;
      bus.rs2 = 5'd16;
      #1;
      vectors++;
      if (bus.cwp !== 2'd3 || bus.rdata2 !== 32'h0) begin
         $display("FAIL write_save_new_win: got cwp=%0d %h expected 3 00000000",
                  bus.cwp, bus.rdata2); errors++;
      end
      bus.restore = 1'b1;
      tick();
      bus.restore = 1'b0;
      #1;
      vectors++;
      if (bus.cwp !== 2'd0 || bus.rdata2 !== 32'hBEEF) begin
         $display("FAIL write_save_old_win: got cwp=%0d %h expected 0 0000beef",
                  bus.cwp, bus.rdata2); errors++;
      end
      bus.wim_we = 1'b1; bus.wim_in = 4'b1000;
      tick();
      bus.wim_we = 1'b0;
      bus.save = 1'b1; bus.we = 1'b1; bus.rd = 5'd2; bus.wdata = 32'h5555;
      Clr = 1'b1;
      tick();
      Clr = 1'b0;
      bus.save = 1'b0; bus.we = 1'b0;
      bus.rs1 = 5'd1; bus.rs2 = 5'd2;
      #1;
      vectors++;
      if (bus.cwp !== 2'd0 || bus.wim !== 4'd0 || bus.window_overflow !== 1'b0) begin
         $display("FAIL clr_fault: got cwp=%0d wim=%b ovf=%b expected 0 0000 0",
                  bus.cwp, bus.wim, bus.window_overflow); errors++;
      end
      vectors++;
      if (bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h0) begin
         $display("FAIL clr_regs: got r1=%h r2=%h expected 00000000 00000000",
                  bus.rdata1, bus.rdata2); errors++;
      end
      tick();
      vectors++;
      if (bus.window_overflow !== 1'b0) begin
         $display("FAIL clr_no_late_trap: got %b expected 0", bus.window_overflow); errors++;
      end
   endtask

   initial begin
      test_reset();
      test_windowing();
      test_overlap();
      test_traps();
      test_bypass();
      test_simultaneous();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
`default_nettype wire
